// File: rtl/itp_mem_pingpong.sv
// ============================================================================
// itp_mem_pingpong
//
// Transpose buffer between the column and row 1-D IDCT stages of the JPEG
// 2-D IDCT. Column vectors (8 coefficients each) are written into one 8x8
// bank while the previously completed block is read out of the other bank
// as 8 row vectors, so streaming sustains one vector per cycle each way.
//
// Parameters
//   BW        coefficient width; every vector is 8*BW bits
//
// Ports
//   i_clk     clock, all state updates on the rising edge
//   i_Reset   synchronous active-high reset
//   i_data    column vector, slice k ([(8-k)*BW-1:(7-k)*BW]) = row k element
//   i_valid   i_data valid
//   o_ready   a column can be accepted this cycle
//   o_data    row vector, slice c = column c of the current row (zero when
//             o_valid is low)
//   o_valid   o_data valid
//   i_ready   downstream accepts o_data this cycle
//   o_last    current o_data is row 7 of its block (present only when the
//             ITP_LAST_FLAG_EN macro is defined)
//
// Build option
//   ITP_LAST_FLAG_EN   adds the o_last port; otherwise identical behaviour.
// ============================================================================
module itp_mem_pingpong #(
    parameter int unsigned BW = 9
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [8*BW-1:0] o_data,
    output logic            o_valid,
    input  logic            i_ready
`ifdef ITP_LAST_FLAG_EN
    ,
    output logic            o_last
`endif
);

    // bank_q[bank][row][col]; contents are intentionally not reset.
    logic [BW-1:0] bank_q [2][8][8];

    logic [1:0] full_q, full_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [2:0] wcnt_q, wcnt_d;
    logic [2:0] rcnt_q, rcnt_d;

    logic wr_fire;
    logic rd_fire;

    // Handshake status is a pure function of registered state.
    assign o_ready = ~full_q[wb_q];
    assign o_valid = full_q[rb_q];

    assign wr_fire = i_valid & o_ready;
    assign rd_fire = o_valid & i_ready;

`ifdef ITP_LAST_FLAG_EN
    assign o_last = o_valid & (rcnt_q == 3'd7);
`endif

    // Row read-out: bank[rb][rcnt][c] lands in slice c, zero when idle.
    always_comb begin
        o_data = '0;
        if (o_valid) begin
            for (int unsigned c = 0; c < 8; c++) begin
                o_data[(7-c)*BW +: BW] = bank_q[rb_q][rcnt_q][c];
            end
        end
    end

    // Next-state for pointers, counters and bank-full flags. A completing
    // write and a completing read always target different banks (write
    // needs the bank empty, read needs it full), so both updates apply.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;

        if (wr_fire) begin
            wcnt_d = wcnt_q + 3'd1;
            if (wcnt_q == 3'd7) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end

        if (rd_fire) begin
            rcnt_d = rcnt_q + 3'd1;
            if (rcnt_q == 3'd7) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Column write: element k of the incoming vector goes to row k, column
    // wcnt of the bank being filled.
    always_ff @(posedge i_clk) begin
        if (wr_fire && !i_Reset) begin
            for (int unsigned k = 0; k < 8; k++) begin
                bank_q[wb_q][k][wcnt_q] <= i_data[(7-k)*BW +: BW];
            end
        end
    end

endmodule

// File: tb/tb_itp_mem_pingpong.sv
// ============================================================================
// tb_itp_mem_pingpong
//
// Self-checking bench for itp_mem_pingpong. A block-level reference model
// (queue of completed 8x8 blocks plus the block currently being filled)
// predicts o_ready/o_valid/o_data every cycle; directed sequences and a
// vector table cover reset, single-block, streaming, backpressure and
// mid-block reset cases.
// ============================================================================
module tb_itp_mem_pingpong;

    localparam int unsigned BW = 9;
    localparam int unsigned VW = 8 * BW;

    typedef logic [63:0][BW-1:0] blk_t;   // element index = row*8 + col

    typedef struct {
        logic          rst;
        logic          vld;
        logic [VW-1:0] dat;
        logic          rdy;
        logic          chk;
        logic          e_ready;
        logic          e_valid;
        logic          e_last;
        logic [VW-1:0] e_data;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [VW-1:0] idata;
    logic          ivalid;
    logic          oready;
    logic [VW-1:0] odata;
    logic          ovalid;
    logic          iready;
`ifdef ITP_LAST_FLAG_EN
    logic          olast;
`endif

    always #5 clk = ~clk;

    itp_mem_pingpong #(.BW(BW)) dut (
        .i_clk   (clk),
        .i_Reset (rst),
        .i_data  (idata),
        .i_valid (ivalid),
        .o_ready (oready),
        .o_data  (odata),
        .o_valid (ovalid),
        .i_ready (iready)
`ifdef ITP_LAST_FLAG_EN
        ,
        .o_last  (olast)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    blk_t        mq[$];
    blk_t        cur;
    int unsigned wcol = 0;
    int unsigned rrow = 0;

    // Per-cycle samples and running counters
    logic          s_ready, s_valid;
    logic [VW-1:0] s_data;
    int            acc_cnt  = 0;
    int            out_cnt  = 0;
    int            last_cnt = 0;

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] col_vec(input int unsigned c);
        logic [VW-1:0] v;
        for (int unsigned r = 0; r < 8; r++) v[(7-r)*BW +: BW] = BW'(8*r + c);
        return v;
    endfunction

    function automatic logic [VW-1:0] row_vec(input int unsigned r);
        logic [VW-1:0] v;
        for (int unsigned c = 0; c < 8; c++) v[(7-c)*BW +: BW] = BW'(8*r + c);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int unsigned k = 0; k < 8; k++) v[k*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    function automatic logic [VW-1:0] model_data();
        logic [VW-1:0] v;
        blk_t          b;
        v = '0;
        if (mq.size() != 0) begin
            b = mq[0];
            for (int unsigned c = 0; c < 8; c++) v[(7-c)*BW +: BW] = b[rrow*8 + c];
        end
        return v;
    endfunction

    // Block-level model: buffer holds at most two completed blocks, reads
    // drain the oldest in row order, writes fill a block column by column.
    function automatic void model_edge();
        bit wf, rf;
        if (rst) begin
            mq.delete();
            wcol = 0;
            rrow = 0;
            return;
        end
        wf = ivalid && (mq.size() < 2);
        rf = iready && (mq.size() != 0);
        if (rf) begin
            if (rrow == 7) begin
                void'(mq.pop_front());
                rrow = 0;
            end else begin
                rrow++;
            end
        end
        if (wf) begin
            for (int unsigned k = 0; k < 8; k++) cur[k*8 + wcol] = idata[(7-k)*BW +: BW];
            if (wcol == 7) begin
                mq.push_back(cur);
                wcol = 0;
            end else begin
                wcol++;
            end
        end
    endfunction

    task automatic tick(input string tag);
        @(negedge clk);
        s_ready = oready;
        s_valid = ovalid;
        s_data  = odata;
        if (ivalid && oready) acc_cnt++;
        if (ovalid && iready) out_cnt++;
`ifdef ITP_LAST_FLAG_EN
        if (olast && ovalid && iready) last_cnt++;
`endif
        if (chk_en) begin
            chk_bit({tag, "_ready"}, oready, mq.size() < 2);
            chk_bit({tag, "_valid"}, ovalid, mq.size() != 0);
            chk_vec({tag, "_data"}, odata, model_data());
`ifdef ITP_LAST_FLAG_EN
            chk_bit({tag, "_last"}, olast, (mq.size() != 0) && (rrow == 7));
`endif
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst    = 1'b1;
        ivalid = 1'b0;
        iready = 1'b0;
        repeat (n) tick("rst");
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        ivalid = 1'b0;
        iready = 1'b1;
        n = 0;
        while (mq.size() != 0 && n < 100) begin
            tick(tag);
            n++;
        end
        chk_bit({tag, "_drain_done"}, n < 100, 1'b1);
    endtask

    vec_t tbl[22];

    initial begin
        int base_acc, base_out, base_last, n, waits, first_v, drops, rows_seen;

        rst    = 1'b1;
        ivalid = 1'b0;
        iready = 1'b0;
        idata  = '0;

        // ---------------- vector table: reset + single block -------------
        for (int i = 0; i < 22; i++) begin
            tbl[i] = '{rst: 1'b0, vld: 1'b0, dat: '0, rdy: 1'b0, chk: 1'b1,
                       e_ready: 1'b1, e_valid: 1'b0, e_last: 1'b0, e_data: '0};
        end
        tbl[0].rst = 1'b1;
        tbl[0].chk = 1'b0;
        tbl[1].rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tbl[3+c].vld = 1'b1;
            tbl[3+c].dat = col_vec(c);
        end
        for (int i = 11; i <= 12; i++) begin
            tbl[i].e_valid = 1'b1;
            tbl[i].e_data  = row_vec(0);
        end
        for (int r = 0; r < 8; r++) begin
            tbl[13+r].rdy     = 1'b1;
            tbl[13+r].e_valid = 1'b1;
            tbl[13+r].e_data  = row_vec(r);
            tbl[13+r].e_last  = (r == 7);
        end
        tbl[21].rdy = 1'b1;

        for (int i = 0; i < 22; i++) begin
            rst    = tbl[i].rst;
            ivalid = tbl[i].vld;
            idata  = tbl[i].dat;
            iready = tbl[i].rdy;
            @(negedge clk);
            if (tbl[i].chk) begin
                chk_bit($sformatf("tbl%0d_ready", i), oready, tbl[i].e_ready);
                chk_bit($sformatf("tbl%0d_valid", i), ovalid, tbl[i].e_valid);
                chk_vec($sformatf("tbl%0d_data", i), odata, tbl[i].e_data);
`ifdef ITP_LAST_FLAG_EN
                chk_bit($sformatf("tbl%0d_last", i), olast, tbl[i].e_last);
`endif
            end
            @(posedge clk);
            model_edge();
            #1;
        end
        chk_en = 1'b1;

        // ---------------- back-to-back streaming of 3 blocks -------------
        do_reset(2);
        base_out = out_cnt;
        first_v  = -1;
        drops    = 0;
        iready   = 1'b1;
        for (int i = 0; i < 34; i++) begin
            ivalid = (i < 24);
            idata  = (i < 24) ? rand_vec() : '0;
            tick("b2b");
            if (i < 24 && !s_ready) drops++;
            if (s_valid && first_v < 0) first_v = i;
        end
        chk_int("b2b_ready_drops", drops, 0);
        chk_int("b2b_first_row_cycle", first_v, 8);
        chk_int("b2b_rows_out", out_cnt - base_out, 24);

        // ---------------- backpressure: two full banks -------------------
        do_reset(1);
        base_acc = acc_cnt;
        ivalid   = 1'b1;
        iready   = 1'b0;
        n = 0;
        while ((acc_cnt - base_acc) < 16 && n < 40) begin
            idata = rand_vec();
            tick("bp_fill");
            n++;
        end
        chk_int("bp_fill_accepts", acc_cnt - base_acc, 16);
        for (int i = 0; i < 5; i++) begin
            idata = rand_vec();
            tick("bp_hold");
            chk_bit("bp_hold_ready", s_ready, 1'b0);
        end
        chk_int("bp_hold_accepts", acc_cnt - base_acc, 16);
        iready = 1'b1;
        waits  = 0;
        n      = 0;
        do begin
            tick("bp_release");
            if (!s_ready) waits++;
            n++;
        end while (!s_ready && n < 20);
        chk_int("bp_release_wait", waits, 8);
        chk_int("bp_17th_accept", acc_cnt - base_acc, 17);
        ivalid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ivalid = 1'b1;
            idata  = rand_vec();
            tick("bp_finish");
        end
        drain("bp");

        // ---------------- mid-block reset --------------------------------
        do_reset(1);
        ivalid = 1'b1;
        iready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idata = '1;
            tick("mr_part");
        end
        do_reset(1);
        ivalid = 1'b0;
        tick("mr_idle");
        chk_bit("mr_after_rst_valid", s_valid, 1'b0);
        chk_bit("mr_after_rst_ready", s_ready, 1'b1);
        for (int c = 0; c < 8; c++) begin
            ivalid = 1'b1;
            idata  = col_vec(c);
            tick("mr_fill");
        end
        ivalid    = 1'b0;
        iready    = 1'b1;
        rows_seen = 0;
        n         = 0;
        while (rows_seen < 8 && n < 20) begin
            tick("mr_read");
            if (s_valid) begin
                chk_vec($sformatf("mr_row%0d", rows_seen), s_data, row_vec(rows_seen));
                rows_seen++;
            end
            n++;
        end
        chk_int("mr_rows", rows_seen, 8);

        // ---------------- random traffic, 100 blocks ---------------------
        do_reset(1);
        base_acc  = acc_cnt;
        base_out  = out_cnt;
        base_last = last_cnt;
        n = 0;
        while ((out_cnt - base_out) < 800 && n < 20000) begin
            ivalid = ((acc_cnt - base_acc) < 800) && (($urandom % 2) == 1);
            idata  = rand_vec();
            iready = ($urandom % 2) == 1;
            tick("rnd");
            n++;
        end
        chk_int("rnd_accepts", acc_cnt - base_acc, 800);
        chk_int("rnd_rows", out_cnt - base_out, 800);
`ifdef ITP_LAST_FLAG_EN
        chk_int("rnd_last_count", last_cnt - base_last, 100);
`else
        base_last = last_cnt;
`endif
        ivalid = 1'b0;
        tick("rnd_idle");
        chk_bit("rnd_idle_valid", s_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
